// File: rtl/pin_collector_pkg.sv
// Shared definitions for the PIN collector and the ATM controller FSM that consumes its output.
// Holds the one-hot state encodings, keypad codes, the PIN nibble width and key decode helpers.
package pin_collector_pkg;

    localparam int unsigned NibbleW = 4;

    localparam logic [3:0] KeyDigitMax = 4'h9;
    localparam logic [3:0] KeyClear    = 4'hA;

    // One-hot collector states; any other encoding decodes to StIdle.
    typedef enum logic [3:0] {
        StIdle    = 4'b0001,
        StCollect = 4'b0010,
        StReady   = 4'b0100,
        StError   = 4'b1000
    } pin_state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KeyDigitMax;
    endfunction

    // Codes 0xB-0xF carry no meaning on the keypad.
    function automatic logic is_bad_key(input logic [3:0] code);
        return code > KeyClear;
    endfunction

endpackage

// File: rtl/pin_timeout_counter.sv
// Inter-key inactivity timer for the PIN collector.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   clear   - return the count to zero (takes priority over run)
//   run     - advance the count by one this cycle
//   expired - count has reached TIMEOUT_CYC-1 (derived from the count register)
module pin_timeout_counter #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            // Saturates at the expiry value; the collector leaves COLLECT on that cycle anyway.
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pin_collector.sv
// Keypad PIN collector: gathers BCD digit strobes into a complete PIN word and offers it to
// the ATM controller over a ready/ack handshake. Supports clear and inter-key timeout.
// Optional feature macro: PIN_TIMEOUT_EN enables the inactivity timer and ERROR state;
// without it COLLECT waits indefinitely and timeout_err is tied low.
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   key_valid   - 1-cycle strobe, key_code valid
//   key_code    - 0x0-0x9 digit, 0xA clear, 0xB-0xF ignored (flagged on bad_key)
//   pin_ack     - controller consumed pin_value (only honoured while pin_ready)
//   pin_ready   - pin_value holds a complete PIN
//   pin_value   - BCD PIN, first digit in the MS nibble
//   digit_count - digits accepted so far
//   timeout_err - 1-cycle pulse when collection is abandoned on timeout
//   bad_key     - 1-cycle pulse one cycle after an unused key code
module pin_collector
    import pin_collector_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    input  logic                          pin_ack,
    output logic                          pin_ready,
    output logic [NibbleW*DIGITS-1:0]     pin_value,
    output logic [$clog2(DIGITS+1)-1:0]   digit_count,
    output logic                          timeout_err,
    output logic                          bad_key
);

    localparam int unsigned PinW = NibbleW * DIGITS;
    localparam int unsigned CntW = $clog2(DIGITS + 1);

    pin_state_e      state_q, state_d;
    logic [PinW-1:0] value_q, value_d;
    logic [CntW-1:0] count_q, count_d;
    logic            bad_key_q, bad_key_d;

    logic key_digit;
    logic key_clear;
    logic timer_expired;

    assign key_digit = key_valid && is_digit(key_code);
    assign key_clear = key_valid && (key_code == KeyClear);

`ifdef PIN_TIMEOUT_EN
    logic timer_clear;
    logic timer_run;

    // Any accepted key, or being outside COLLECT, restarts the idle window.
    assign timer_clear = (state_q != StCollect) || key_digit || key_clear;
    assign timer_run   = (state_q == StCollect);

    pin_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (timer_expired)
    );
`else
    assign timer_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        count_d   = count_q;
        bad_key_d = key_valid && is_bad_key(key_code);

        case (state_q)
            StIdle, StCollect: begin
                if (key_digit) begin
                    value_d = {value_q[PinW-NibbleW-1:0], key_code};
                    count_d = count_q + CntW'(1);
                    state_d = (count_d == CntW'(DIGITS)) ? StReady : StCollect;
                end else if (key_clear) begin
                    value_d = '0;
                    count_d = '0;
                    state_d = StIdle;
                end else if ((state_q == StCollect) && timer_expired) begin
                    value_d = '0;
                    count_d = '0;
                    state_d = StError;
                end
            end
            StReady: begin
                // Keys are dropped here; an ack in the same cycle as a key still wins.
                if (pin_ack) begin
                    value_d = '0;
                    count_d = '0;
                    state_d = StIdle;
                end
            end
            StError: begin
                state_d = StIdle;
            end
            default: begin
                value_d = '0;
                count_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            value_q   <= '0;
            count_q   <= '0;
            bad_key_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            count_q   <= count_d;
            bad_key_q <= bad_key_d;
        end
    end

    assign pin_ready   = (state_q == StReady);
    assign pin_value   = value_q;
    assign digit_count = count_q;
    assign bad_key     = bad_key_q;
`ifdef PIN_TIMEOUT_EN
    assign timeout_err = (state_q == StError);
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pin_collector.sv
// Directed self-checking bench for pin_collector (DIGITS=4, TIMEOUT_CYC=8).
module tb_pin_collector;

    localparam int unsigned DIGITS      = 4;
    localparam int unsigned TIMEOUT_CYC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        pin_ack;
    logic        pin_ready;
    logic [15:0] pin_value;
    logic [2:0]  digit_count;
    logic        timeout_err;
    logic        bad_key;

    int n_checks = 0;
    int n_errors = 0;

    pin_collector #(
        .DIGITS      (DIGITS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .pin_ack     (pin_ack),
        .pin_ready   (pin_ready),
        .pin_value   (pin_value),
        .digit_count (digit_count),
        .timeout_err (timeout_err),
        .bad_key     (bad_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ack();
        pin_ack = 1'b1;
        tick();
        pin_ack = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic rdy, input logic [15:0] val,
                                 input logic [2:0] cnt);
        check({tag, ".ready"}, 32'(pin_ready), 32'(rdy));
        check({tag, ".value"}, 32'(pin_value), 32'(val));
        check({tag, ".count"}, 32'(digit_count), 32'(cnt));
    endtask

    initial begin
        int err_seen;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        pin_ack   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_outputs("reset", 1'b0, 16'h0000, 3'd0);
        check("reset.timeout_err", 32'(timeout_err), 32'd0);
        check("reset.bad_key", 32'(bad_key), 32'd0);

        // 1: basic PIN with gaps
        press(4'h1); idle(3);
        press(4'h2); idle(3);
        press(4'h3);
        check_outputs("t1.three", 1'b0, 16'h0123, 3'd3);
        idle(3);
        press(4'h4);
        check_outputs("t1.full", 1'b1, 16'h1234, 3'd4);
        idle(2);
        check_outputs("t1.hold", 1'b1, 16'h1234, 3'd4);
        ack();
        check_outputs("t1.ack", 1'b0, 16'h0000, 3'd0);

        // 2: clear mid-collection
        press(4'h5); press(4'h6);
        check_outputs("t2.two", 1'b0, 16'h0056, 3'd2);
        press(4'hA);
        check_outputs("t2.clear", 1'b0, 16'h0000, 3'd0);
        press(4'h7); press(4'h8); press(4'h9); press(4'h0);
        check_outputs("t2.full", 1'b1, 16'h7890, 3'd4);

        // 4: READY behaviour
        press(4'hC);
        check("t4.bad_key", 32'(bad_key), 32'd1);
        check_outputs("t4.badready", 1'b1, 16'h7890, 3'd4);
        tick();
        check("t4.bad_key_off", 32'(bad_key), 32'd0);
        press(4'h5);
        check_outputs("t4.keydrop", 1'b1, 16'h7890, 3'd4);
        pin_ack = 1'b1;
        press(4'h9);
        pin_ack = 1'b0;
        check_outputs("t4.ackkey", 1'b0, 16'h0000, 3'd0);
        press(4'h1);
        check_outputs("t4.after", 1'b0, 16'h0001, 3'd1);
        press(4'hA);
        check_outputs("t4.clear", 1'b0, 16'h0000, 3'd0);

        // 5: reset mid-collection, then a normal PIN
        press(4'h2); press(4'h3);
        rst = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'hF;
        tick();
        rst = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        check_outputs("t5.rst", 1'b0, 16'h0000, 3'd0);
        check("t5.rst.bad_key", 32'(bad_key), 32'd0);
        check("t5.rst.timeout_err", 32'(timeout_err), 32'd0);
        press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        check_outputs("t5.full", 1'b1, 16'h9876, 3'd4);
        ack();
        check_outputs("t5.ack", 1'b0, 16'h0000, 3'd0);

`ifdef PIN_TIMEOUT_EN
        // 3: timeout after TIMEOUT_CYC idle COLLECT cycles
        press(4'h3);
        err_seen = 0;
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
            tick();
            if (timeout_err) err_seen++;
        end
        check("t3.early_err", 32'(err_seen), 32'd0);
        check("t3.early_cnt", 32'(digit_count), 32'd1);
        tick();
        check("t3.err", 32'(timeout_err), 32'd1);
        check_outputs("t3.errclr", 1'b0, 16'h0000, 3'd0);
        err_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (timeout_err) err_seen++;
        end
        check("t3.once", 32'(err_seen), 32'd0);
        check("t3.cnt_after", 32'(digit_count), 32'd0);

        // key in the expiry cycle wins
        press(4'h3);
        idle(TIMEOUT_CYC - 1);
        press(4'h4);
        check("t3.win_err", 32'(timeout_err), 32'd0);
        check_outputs("t3.win", 1'b0, 16'h0034, 3'd2);
        err_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (timeout_err) err_seen++;
        end
        check("t3.win_noerr", 32'(err_seen), 32'd0);
        press(4'hA);
`else
        // 6: no timer, COLLECT waits indefinitely
        press(4'h1);
        err_seen = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (timeout_err) err_seen++;
        end
        check("t6.noerr", 32'(err_seen), 32'd0);
        check_outputs("t6.wait", 1'b0, 16'h0001, 3'd1);
        press(4'hA);
`endif
        check_outputs("end", 1'b0, 16'h0000, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
